// File: rtl/boreal_boot_pkg.sv
// Purpose : shared types and helpers for the multi-slot measured-boot ROM.
// Latency : n/a (types, constants and constant functions only).
// Backpres: n/a.
// Contents: boot FSM state encoding, per-slot status codes, width and slot-index helpers.
package boreal_boot_pkg;

   typedef enum logic [3:0] {
      IDLE, S_INIT, S_WAIT, FEED, GAP, H_DONE, V_START, V_WAIT, V_CHK, NEXT, DONE
   } boot_state_e;

   typedef enum logic [1:0] {
      ST_UNTRIED = 2'b00,
      ST_PASS    = 2'b01,
      ST_SIGFAIL = 2'b10,
      ST_TIMEOUT = 2'b11
   } slot_status_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Slot-index width; at least one bit so a single-slot build still has a port.
   function automatic int slot_w(input int slots);
      return (clog2(slots) < 1) ? 1 : clog2(slots);
   endfunction

   // Preferred slot outside the populated range falls back to slot 0.
   function automatic int clamp_slot(input int pref, input int slots);
      return (pref >= slots) ? 0 : pref;
   endfunction

   function automatic int next_slot(input int cur, input int slots);
      return (cur + 1 >= slots) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/boreal_bootrom_ms_if.sv
// Purpose : read-only system bus window of the boot ROM.
// Latency : rdata/ack one cycle after sel.
// Backpres: none; every selected cycle is acknowledged.
// Signals : sel (select), addr (byte address), rdata (read data), ack (read acknowledge).
interface boreal_bootrom_ms_if;
   logic        sel;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        ack;

   modport master (output sel, output addr, input rdata, input ack);
   modport slave  (input sel, input addr, output rdata, output ack);
endinterface

// File: rtl/boreal_bootrom_mem.sv
// Purpose : image ROM with two independent registered read ports (bus and hash feed).
// Latency : one cycle from address to data on each port.
// Backpres: none; both ports read every cycle.
// Ports   : clk; bus_addr/bus_rdat (bus window); hash_addr/hash_rdat (hash engine feed).
module boreal_bootrom_mem #(
   parameter int    DEPTH     = 2048,
   parameter int    AW        = 11,
   parameter string INIT_FILE = ""
) (
   input  logic          clk,
   input  logic [AW-1:0] bus_addr,
   output logic [31:0]   bus_rdat,
   input  logic [AW-1:0] hash_addr,
   output logic [31:0]   hash_rdat
);

   logic [31:0] rom [DEPTH];
   logic [31:0] bus_rdat_q, bus_rdat_d;
   logic [31:0] hash_rdat_q, hash_rdat_d;

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
   end

   // Address space may be wider than the populated depth (non-power-of-two slot count).
   always_comb begin
      bus_rdat_d  = (int'(bus_addr)  < DEPTH) ? rom[bus_addr]  : '0;
      hash_rdat_d = (int'(hash_addr) < DEPTH) ? rom[hash_addr] : '0;
   end

   always_ff @(posedge clk) begin
      bus_rdat_q  <= bus_rdat_d;
      hash_rdat_q <= hash_rdat_d;
   end

   assign bus_rdat  = bus_rdat_q;
   assign hash_rdat = hash_rdat_q;

endmodule

// File: rtl/boreal_bootrom_ms.sv
// Purpose : multi-slot measured-boot ROM: hash + verify each slot, fall back on failure/timeout.
// Latency : bus read 1 cycle; one image word to the hash engine at most every 2 cycles.
// Backpres: engines pace the FSM via sha_ready/sig_ready, bounded by TIMEOUT; bus never stalls.
// Ports   : clk/rst; bus (read-only slave window); boot_restart/boot_pref control;
//           boot_done/pass/slot/hash_out/status results; sha_* and sig_* engine handshakes.
module boreal_bootrom_ms
   import boreal_boot_pkg::*;
#(
   parameter int    SLOTS      = 2,
   parameter int    SLOT_WORDS = 1024,
   parameter string INIT_FILE  = "",
   parameter int    TIMEOUT    = 4096,
   parameter bit    REMAP      = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   boreal_bootrom_ms_if.slave         bus,
   input  logic                       boot_restart,
   input  logic [slot_w(SLOTS)-1:0]   boot_pref,
   output logic                       boot_done,
   output logic                       boot_pass,
   output logic [slot_w(SLOTS)-1:0]   boot_slot,
   output logic [31:0]                boot_hash_out,
   output logic [2*SLOTS-1:0]         boot_status,
   output logic                       sha_start,
   output logic                       sha_update,
   output logic [31:0]                sha_data,
   input  logic [31:0]                sha_hash,
   input  logic                       sha_ready,
   output logic                       sig_start,
   output logic [31:0]                sig_hash_in,
   input  logic                       sig_pass,
   input  logic                       sig_ready
);

   localparam int SW = slot_w(SLOTS);
   localparam int IW = clog2(SLOT_WORDS);
   localparam int AW = SW + IW;
   localparam int TW = clog2(TIMEOUT + 1);
   localparam int CW = clog2(SLOTS + 1);

   boot_state_e        state_q, state_d;
   logic [SW-1:0]      cur_q, cur_d, slot_q, slot_d;
   logic [IW:0]        idx_q, idx_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [CW-1:0]      tries_q, tries_d, tries_inc;
   logic [2*SLOTS-1:0] status_q, status_d;
   logic [31:0]        hash_q, hash_d;
   logic               done_q, done_d, pass_q, pass_d;
   logic               ack_q, ack_d, rd_ok_q, rd_ok_d;
   logic               tmo, idx_end, upd, in_range;
   logic [AW-1:0]      hash_addr, bus_addr;
   logic [31:0]        hash_rdat, bus_rdat;

   // Timer only matters in the states that wait on an engine.
   assign tmo = (timer_q == TW'(TIMEOUT)) &&
                (state_q inside {S_WAIT, FEED, H_DONE, V_WAIT, V_CHK});
   assign idx_end   = (idx_q == (IW+1)'(SLOT_WORDS));
   assign upd       = (state_q == FEED) && !idx_end && sha_ready && !tmo;
   assign tries_inc = tries_q + 1'b1;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = S_INIT;
         S_INIT:  state_d = S_WAIT;
         S_WAIT:  if (tmo) state_d = NEXT; else if (sha_ready) state_d = FEED;
         FEED:    if (tmo) state_d = NEXT; else if (idx_end) state_d = H_DONE;
                  else if (sha_ready) state_d = GAP;
         GAP:     state_d = FEED;
         H_DONE:  if (tmo) state_d = NEXT; else if (sha_ready) state_d = V_START;
         V_START: state_d = V_WAIT;
         // Wait for the verifier to drop ready, so a stale ready is never taken as a result.
         V_WAIT:  if (tmo) state_d = NEXT; else if (!sig_ready) state_d = V_CHK;
         V_CHK:   if (tmo) state_d = NEXT;
                  else if (sig_ready) state_d = sig_pass ? DONE : NEXT;
         NEXT:    state_d = (tries_inc == CW'(SLOTS)) ? DONE : S_INIT;
         DONE:    if (boot_restart) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath / outputs ----------------
   always_comb begin
      cur_d    = cur_q;
      slot_d   = slot_q;
      idx_d    = idx_q;
      tries_d  = tries_q;
      status_d = status_q;
      hash_d   = hash_q;
      done_d   = done_q;
      pass_d   = pass_q;
      timer_d  = (state_d != state_q) ? '0 : ((&timer_q) ? timer_q : timer_q + 1'b1);
      case (state_q)
         IDLE: begin
            cur_d    = SW'(clamp_slot(int'(boot_pref), SLOTS));
            tries_d  = '0;
            status_d = '0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
         end
         S_WAIT: if (state_d == FEED) idx_d = '0;
         FEED:   if (upd) idx_d = idx_q + 1'b1;
         H_DONE: if (state_d == V_START) hash_d = sha_hash;
         V_CHK: begin
            if (!tmo && sig_ready) begin
               if (sig_pass) begin
                  status_d[int'(cur_q)*2 +: 2] = ST_PASS;
                  slot_d = cur_q;
                  done_d = 1'b1;
                  pass_d = 1'b1;
               end else begin
                  status_d[int'(cur_q)*2 +: 2] = ST_SIGFAIL;
               end
            end
         end
         NEXT: begin
            tries_d = tries_inc;
            if (tries_inc == CW'(SLOTS)) done_d = 1'b1;
            else                         cur_d  = SW'(next_slot(int'(cur_q), SLOTS));
         end
         DONE: begin
            if (boot_restart) begin
               done_d = 1'b0;
               pass_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (tmo) status_d[int'(cur_q)*2 +: 2] = ST_TIMEOUT;
   end

   // Hash port is addressed from next-state values so the registered ROM word
   // for {cur_q, idx_q} is ready in the FEED cycle that sends it.
   always_comb begin
      hash_addr = {cur_d, idx_d[IW-1:0]};
      if (REMAP) begin
         bus_addr = {slot_q, bus.addr[IW+1:2]};
         in_range = 1'b1;
      end else begin
         bus_addr = bus.addr[AW+1:2];
         in_range = (bus.addr[31:2] < 30'(SLOTS * SLOT_WORDS));
      end
      ack_d   = bus.sel;
      rd_ok_d = bus.sel && done_q && pass_q && in_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q    <= '0;
         slot_q   <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         tries_q  <= '0;
         status_q <= '0;
         hash_q   <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         ack_q    <= 1'b0;
         rd_ok_q  <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         timer_q  <= timer_d;
         tries_q  <= tries_d;
         status_q <= status_d;
         hash_q   <= hash_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         ack_q    <= ack_d;
         rd_ok_q  <= rd_ok_d;
      end
   end

   boreal_bootrom_mem #(
      .DEPTH     (SLOTS * SLOT_WORDS),
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_mem (
      .clk       (clk),
      .bus_addr  (bus_addr),
      .bus_rdat  (bus_rdat),
      .hash_addr (hash_addr),
      .hash_rdat (hash_rdat)
   );

   assign bus.ack       = ack_q;
   assign bus.rdata     = rd_ok_q ? bus_rdat : '0;
   assign boot_done     = done_q;
   assign boot_pass     = pass_q;
   assign boot_slot     = slot_q;
   assign boot_hash_out = hash_q;
   assign boot_status   = status_q;
   assign sig_hash_in   = hash_q;
   assign sha_start     = (state_q == S_INIT);
   assign sha_update    = upd;
   assign sha_data      = upd ? hash_rdat : '0;
   assign sig_start     = (state_q == V_START);

endmodule

// File: tb/tb_boreal_bootrom_ms.sv
// Purpose : directed bench for the multi-slot boot ROM with behavioural SHA and verifier models.
// Latency : n/a.
// Backpres: n/a.
module tb_boreal_bootrom_ms;

   logic        clk;
   logic        rst;
   logic        boot_restart;
   logic [0:0]  boot_pref;
   logic        boot_done, boot_pass;
   logic [0:0]  boot_slot;
   logic [31:0] boot_hash_out;
   logic [3:0]  boot_status;
   logic        sha_start, sha_update;
   logic [31:0] sha_data, sha_hash;
   logic        sha_ready;
   logic        sig_start;
   logic [31:0] sig_hash_in;
   logic        sig_pass  = 1'b0;
   logic        sig_ready = 1'b1;

   logic        sha_rdy_en;
   logic [1:0]  signed_mask;
   logic [31:0] img [32];
   logic [31:0] eh0, eh1;
   logic [31:0] acc = '0;
   int          sig_busy = 0;
   int          upd_cnt = 0, adj_cnt = 0;
   logic        prev_upd = 1'b0;
   int          checks = 0, errors = 0;
   int          u0, a0;

   boreal_bootrom_ms_if bus_if ();

   boreal_bootrom_ms #(
      .SLOTS(2), .SLOT_WORDS(16), .INIT_FILE(""), .TIMEOUT(64), .REMAP(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .boot_restart(boot_restart), .boot_pref(boot_pref),
      .boot_done(boot_done), .boot_pass(boot_pass), .boot_slot(boot_slot),
      .boot_hash_out(boot_hash_out), .boot_status(boot_status),
      .sha_start(sha_start), .sha_update(sha_update), .sha_data(sha_data),
      .sha_hash(sha_hash), .sha_ready(sha_ready),
      .sig_start(sig_start), .sig_hash_in(sig_hash_in), .sig_pass(sig_pass), .sig_ready(sig_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Toy hash: rotate-left-5 then xor each word, seeded at start.
   assign sha_ready = sha_rdy_en;
   assign sha_hash  = acc;
   always @(posedge clk) begin
      if (sha_start)       acc <= 32'h6A09E667;
      else if (sha_update) acc <= {acc[26:0], acc[31:27]} ^ sha_data;
      if (sha_update) upd_cnt <= upd_cnt + 1;
      if (sha_update && prev_upd) adj_cnt <= adj_cnt + 1;
      prev_upd <= sha_update;
   end

   // Verifier: busy for 3 cycles, accepts a hash only if it is a signed slot's image hash.
   always @(posedge clk) begin
      if (sig_start) begin
         sig_busy  <= 3;
         sig_ready <= 1'b0;
         sig_pass  <= (signed_mask[0] && sig_hash_in == eh0) ||
                      (signed_mask[1] && sig_hash_in == eh1);
      end else if (sig_busy != 0) begin
         sig_busy <= sig_busy - 1;
         if (sig_busy == 1) sig_ready <= 1'b1;
      end
   end

   function automatic logic [31:0] exp_hash(input int s);
      logic [31:0] h;
      h = 32'h6A09E667;
      for (int w = 0; w < 16; w++) h = {h[26:0], h[31:27]} ^ img[s*16 + w];
      return h;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_restart();
      boot_restart = 1'b1;
      tick();
      boot_restart = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (boot_done !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      check(tag, 32'(boot_done), 32'd1);
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus_if.sel  = 1'b1;
      bus_if.addr = a;
      tick();
      bus_if.sel  = 1'b0;
      check({tag, "_ack"}, 32'(bus_if.ack), 32'd1);
      check({tag, "_rdata"}, bus_if.rdata, exp);
   endtask

   initial begin
      rst = 1'b1; boot_restart = 1'b0; boot_pref = 1'b0;
      bus_if.sel = 1'b0; bus_if.addr = '0;
      sha_rdy_en = 1'b1; signed_mask = 2'b01;
      #1;
      for (int i = 0; i < 32; i++) begin
         img[i] = 32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9);
         dut.u_mem.rom[i] = img[i];
      end
      eh0 = exp_hash(0);
      eh1 = exp_hash(1);
      repeat (3) tick();

      // Reset state
      check("rst_done",   32'(boot_done),   32'd0);
      check("rst_pass",   32'(boot_pass),   32'd0);
      check("rst_status", 32'(boot_status), 32'd0);
      check("rst_sha_start", 32'(sha_start), 32'd0);
      check("rst_sig_start", 32'(sig_start), 32'd0);
      check("rst_hash",   boot_hash_out,    32'd0);

      // 1: slot0 signed
      u0 = upd_cnt; a0 = adj_cnt;
      rst = 1'b0;
      wait_done("t1_done");
      check("t1_pass",   32'(boot_pass),   32'd1);
      check("t1_slot",   32'(boot_slot),   32'd0);
      check("t1_status", 32'(boot_status), 32'b0001);
      check("t1_hash",   boot_hash_out,    eh0);
      check("t1_updates", 32'(upd_cnt - u0), 32'd16);
      check("t1_adjacent", 32'(adj_cnt - a0), 32'd0);
      bus_read(32'h4,  img[1],  "t1_rd1");
      bus_read(32'h3C, img[15], "t1_rd15");

      // 2: slot0 fails, slot1 signed
      signed_mask = 2'b10;
      pulse_restart();
      wait_done("t2_done");
      check("t2_pass",   32'(boot_pass),   32'd1);
      check("t2_slot",   32'(boot_slot),   32'd1);
      check("t2_status", 32'(boot_status), 32'b0110);
      check("t2_hash",   boot_hash_out,    eh1);
      bus_read(32'h0,  img[16], "t2_rd0");
      bus_read(32'h3C, img[31], "t2_rd15");

      // 3: both fail
      signed_mask = 2'b00;
      pulse_restart();
      wait_done("t3_done");
      check("t3_pass",   32'(boot_pass),   32'd0);
      check("t3_status", 32'(boot_status), 32'b1010);
      bus_read(32'h0, 32'd0, "t3_rd0");
      bus_read(32'h8, 32'd0, "t3_rd2");

      // 4: sha_ready stuck low on slot0 -> timeout, slot1 then boots
      signed_mask = 2'b10;
      sha_rdy_en  = 1'b0;
      pulse_restart();
      repeat (30) tick();
      check("t4_pass_while_busy", 32'(boot_pass), 32'd0);
      bus_read(32'h0, 32'd0, "t4_rd_busy");
      repeat (29) tick();
      check("t4_before_tmo", 32'(boot_status[1:0]), 32'b00);
      repeat (10) tick();
      check("t4_after_tmo",  32'(boot_status[1:0]), 32'b11);
      sha_rdy_en = 1'b1;
      wait_done("t4_done");
      check("t4_pass",   32'(boot_pass),   32'd1);
      check("t4_slot",   32'(boot_slot),   32'd1);
      check("t4_status", 32'(boot_status), 32'b0111);

      // 5: pref=1, restart mid-FEED ignored
      boot_pref = 1'b1;
      u0 = upd_cnt;
      pulse_restart();
      repeat (10) tick();
      pulse_restart();
      wait_done("t5_done");
      check("t5_pass",    32'(boot_pass),   32'd1);
      check("t5_slot",    32'(boot_slot),   32'd1);
      check("t5_status",  32'(boot_status), 32'b0100);
      check("t5_updates", 32'(upd_cnt - u0), 32'd16);

      // 6: rst for one cycle mid-FEED
      boot_pref   = 1'b0;
      signed_mask = 2'b01;
      pulse_restart();
      repeat (12) tick();
      rst = 1'b1;
      tick();
      check("t6_done",   32'(boot_done),   32'd0);
      check("t6_pass",   32'(boot_pass),   32'd0);
      check("t6_slot",   32'(boot_slot),   32'd0);
      check("t6_status", 32'(boot_status), 32'd0);
      check("t6_hash",   boot_hash_out,    32'd0);
      check("t6_upd",    32'(sha_update),  32'd0);
      check("t6_sha_data", sha_data,       32'd0);
      check("t6_sig_hash", sig_hash_in,    32'd0);
      u0 = upd_cnt; a0 = adj_cnt;
      rst = 1'b0;
      wait_done("t6_rerun_done");
      check("t6_rerun_pass",   32'(boot_pass),   32'd1);
      check("t6_rerun_status", 32'(boot_status), 32'b0001);
      check("t6_rerun_hash",   boot_hash_out,    eh0);
      check("t6_rerun_updates", 32'(upd_cnt - u0), 32'd16);
      check("t6_rerun_adjacent", 32'(adj_cnt - a0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
